conv_sched: RTL and testbench
=============================

Name: conv_sched

Overview:
- Sequencer between the 8x8 pixel RAM and the Conv engine. It loads a 64-pixel frame into RAM from a valid/ready stream.
- It then issues RAM read addresses in 3x3 window order for all 36 valid output positions, with stride 1, giving a 6x6 output.
- It asserts the Conv input strobe aligned to RAM read data, and collects the 36 Conv results into a small output FIFO with backpressure.
- It replaces the hand-sequenced address/wr/in_st stimulus used around RAM and Conv today.

Parameters:
IMG_W, 8, image width in pixels
IMG_H, 8, image height in pixels
K, 3, kernel edge; one window is K*K reads
AW, 6, RAM address width; must satisfy 2^AW >= IMG_W*IMG_H
DW, 8, pixel width
RW, 16, Conv result width
FIFO_DEPTH, 4, result FIFO entries; power of two

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  1-cycle pulse; begins LOAD; ignored unless in IDLE
load_valid  in  1  pixel stream valid
load_data  in  DW  pixel value
load_ready  out  1  high only in LOAD
ram_wr  out  1  RAM write enable
ram_addr  out  AW  RAM address
ram_din  out  DW  RAM write data
conv_in_st  out  1  Conv strobe; high when RAM dout holds a window pixel
conv_first  out  1  qualifies conv_in_st on the first pixel of each window
conv_dout  in  RW  Conv result
conv_out_st  in  1  Conv result valid
res_valid  out  1  FIFO not empty
res_data  out  RW  FIFO head
res_ready  in  1  downstream accept
busy  out  1  high when not in IDLE
done  out  1  1-cycle pulse at frame end

Behaviour:
- Reset (async, rst_n=0): state IDLE; all counters 0; FIFO empty. Outputs: load_ready=0, ram_wr=0, ram_addr=0, ram_din=0, conv_in_st=0, conv_first=0, res_valid=0, res_data=0, busy=0, done=0.
- Reset mid-operation aborts the frame. No result is retained.
- FSM IDLE -> LOAD -> SCAN -> DRAIN -> DONE -> IDLE.
- IDLE: when start=1, go to LOAD next cycle.
- LOAD: load_ready=1. On each load_valid&&load_ready: ram_wr=1, ram_addr=wcnt, ram_din=load_data (registered, visible the next cycle), wcnt++. Pixels land row-major. After handshake number IMG_W*IMG_H, go to SCAN; ram_wr deasserts the cycle after.
- SCAN: ram_wr=0. Counters oy, ox in 0..IMG_H-K and 0..IMG_W-K; ky, kx in 0..K-1.
  - ram_addr = (oy+ky)*IMG_W + (ox+kx).
  - Index order: kx fastest, then ky, ox, oy.
  - RAM read latency is 1 cycle. conv_in_st and conv_first are delayed one register stage from the issue of the address.
- Window issue gating: a new window (kx=ky=0) issues only if outstanding + fifo_count < FIFO_DEPTH.
  - outstanding = windows issued minus conv_out_st pulses received.
  - Inside a window, the 9 reads issue back-to-back with no stall.
- After the last read of window (IMG_H-K, IMG_W-K), go to DRAIN.
- DRAIN: wait until results received = 36 and the FIFO is empty, then go to DONE.
- DONE: done=1 for one cycle; busy stays 1 in this cycle. Return to IDLE.
- FIFO: conv_out_st pushes conv_dout. Pop on res_valid&&res_ready. Push and pop in the same cycle leave the count unchanged.
  - Push while full cannot occur, because of the issue gating.
  - A conv_out_st received with no window outstanding is a protocol error; the result is dropped (assertion in sim).
- Counter widths are sized with $clog2. Address arithmetic is unsigned with no wrap, since the maximum is IMG_W*IMG_H-1.

Optional Feature:
- Macro CONV_SCHED_PERF_EN.
- Defined: adds output port stall_cycles [15:0]. It counts SCAN cycles in which a window issue was blocked by gating, saturates at 16'hFFFF, and clears on start.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package conv_pkg holds:
  - the state enum (IDLE, LOAD, SCAN, DRAIN, DONE);
  - IMG_W, IMG_H, K and derived OUT_W=IMG_W-K+1, OUT_H=IMG_H-K+1, NUM_WIN=OUT_W*OUT_H, WIN_LEN=K*K.
- One sub-module, conv_res_fifo: synchronous FIFO with parameters RW and FIFO_DEPTH, ports push/pop/count, and the same clk/rst_n.

Test Plan:
- Reset, start, stream pixels 0..63 with load_valid always high -> 64 ram_wr cycles at addr 0..63; load_ready=0 afterwards; busy=1.
- First SCAN window -> ram_addr sequence 0,1,2,8,9,10,16,17,18. conv_first is high only with the strobe for addr 0. Window 1 starts at addr 1; window 6 starts at 8; window 35 is 45,46,47,53,54,55,61,62,63.
- Conv model with 5-cycle latency returning the window sum, res_ready=1 -> 36 results in order; the first equals 0+1+2+8+9+10+16+17+18=81. done pulses once, then busy=0.
- Hold res_ready=0 -> at most 4 windows outstanding. No FIFO overflow; issue resumes when res_ready rises; all 36 results intact.
- Assert rst_n=0 during SCAN window 10 -> all outputs return to reset values immediately. A new start then runs a full, correct frame.
- start pulsed while busy -> ignored. With CONV_SCHED_PERF_EN defined and res_ready=0 for 20 cycles, stall_cycles > 0 and stops at the blocked-cycle count.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared geometry and state encoding for the conv_sched sequencer.
package conv_pkg;

   localparam int unsigned IMG_W   = 8;
   localparam int unsigned IMG_H   = 8;
   localparam int unsigned K       = 3;
   localparam int unsigned OUT_W   = IMG_W - K + 1;
   localparam int unsigned OUT_H   = IMG_H - K + 1;
   localparam int unsigned NUM_WIN = OUT_W * OUT_H;
   localparam int unsigned WIN_LEN = K * K;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SCAN,
      DRAIN,
      DONE
   } state_t;

endpackage

// File: rtl/conv_res_fifo.sv
// Small synchronous result FIFO; FIFO_DEPTH must be a power of two so the
// pointers wrap naturally.
module conv_res_fifo #(
   parameter int unsigned RW         = 16,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                push,
   input  logic [RW-1:0]                       din,
   input  logic                                pop,
   output logic [RW-1:0]                       dout,
   output logic                                valid,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]     count
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

   logic [RW-1:0] r_mem [FIFO_DEPTH];
   logic [PW-1:0] r_wp;
   logic [PW-1:0] r_rp;
   logic [CW-1:0] r_cnt;
   logic          w_push;
   logic          w_pop;

   assign w_push = push && (r_cnt != CW'(FIFO_DEPTH));
   assign w_pop  = pop && (r_cnt != '0);

   // Storage, pointers and occupancy; memory is cleared so the head reads 0 after reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wp] <= din;
            r_wp        <= r_wp + PW'(1);
         end
         if (w_pop) r_rp <= r_rp + PW'(1);
         unique case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + CW'(1);
            2'b01:   r_cnt <= r_cnt - CW'(1);
            default: ;
         endcase
      end
   end

   assign dout  = r_mem[r_rp];
   assign valid = (r_cnt != '0);
   assign count = r_cnt;

endmodule

// File: rtl/conv_sched.sv
// conv_sched: loads an 8x8 frame into pixel RAM, scans 3x3 windows for the
// Conv engine and buffers results. Optional macro CONV_SCHED_PERF_EN adds a
// saturating stall_cycles counter output.
module conv_sched
   import conv_pkg::*;
#(
   parameter int unsigned AW         = 6,
   parameter int unsigned DW         = 8,
   parameter int unsigned RW         = 16,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          load_valid,
   input  logic [DW-1:0] load_data,
   output logic          load_ready,
   output logic          ram_wr,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_din,
   output logic          conv_in_st,
   output logic          conv_first,
   input  logic [RW-1:0] conv_dout,
   input  logic          conv_out_st,
   output logic          res_valid,
   output logic [RW-1:0] res_data,
   input  logic          res_ready,
   output logic          busy,
`ifdef CONV_SCHED_PERF_EN
   output logic [15:0]   stall_cycles,
`endif
   output logic          done
);

   localparam int unsigned KW  = $clog2(K);
   localparam int unsigned OXW = $clog2(OUT_W);
   localparam int unsigned OYW = $clog2(OUT_H);
   localparam int unsigned RCW = $clog2(NUM_WIN + 1);
   localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);

   state_t         r_state, w_state_nxt;
   logic [AW-1:0]  r_wcnt;
   logic [KW-1:0]  r_kx, r_ky;
   logic [OXW-1:0] r_ox;
   logic [OYW-1:0] r_oy;
   logic [CW-1:0]  r_outst;
   logic [RCW-1:0] r_rcnt;
   logic           r_ram_wr;
   logic [AW-1:0]  r_ram_addr;
   logic [DW-1:0]  r_ram_din;
   logic           r_rd_vld, r_rd_first, r_in_st, r_first;

   logic           w_start;
   logic           w_load_hs;
   logic           w_win_start;
   logic           w_gate_ok;
   logic           w_issue;
   logic           w_win_issue;
   logic           w_last_rd;
   logic           w_res_acc;
   logic           w_pop;
   logic           w_fifo_valid;
   logic [CW-1:0]  w_fifo_count;
   logic [AW-1:0]  w_addr;

   assign w_start     = (r_state == IDLE) && start;
   assign w_load_hs   = load_valid && load_ready;
   assign w_win_start = (r_kx == '0) && (r_ky == '0);
   assign w_gate_ok   = ({1'b0, r_outst} + {1'b0, w_fifo_count}) < (CW+1)'(FIFO_DEPTH);
   assign w_issue     = (r_state == SCAN) && (!w_win_start || w_gate_ok);
   assign w_win_issue = w_issue && w_win_start;
   assign w_last_rd   = (r_kx == KW'(K-1)) && (r_ky == KW'(K-1)) &&
                        (r_ox == OXW'(OUT_W-1)) && (r_oy == OYW'(OUT_H-1));
   assign w_res_acc   = conv_out_st && (r_outst != '0);
   assign w_pop       = w_fifo_valid && res_ready;
   assign w_addr      = AW'((32'(r_oy) + 32'(r_ky)) * IMG_W + 32'(r_ox) + 32'(r_kx));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state and state-decoded outputs
   always_comb begin
      w_state_nxt = r_state;
      load_ready  = 1'b0;
      busy        = 1'b1;
      done        = 1'b0;
      unique case (r_state)
         IDLE: begin
            busy = 1'b0;
            if (start) w_state_nxt = LOAD;
         end
         LOAD: begin
            load_ready = 1'b1;
            if (w_load_hs && (r_wcnt == AW'(IMG_W*IMG_H-1))) w_state_nxt = SCAN;
         end
         SCAN: begin
            if (w_issue && w_last_rd) w_state_nxt = DRAIN;
         end
         DRAIN: begin
            if ((r_rcnt == RCW'(NUM_WIN)) && !w_fifo_valid) w_state_nxt = DONE;
         end
         DONE: begin
            done        = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // RAM port: write pixels during LOAD, read addresses during SCAN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wcnt     <= '0;
         r_ram_wr   <= 1'b0;
         r_ram_addr <= '0;
         r_ram_din  <= '0;
      end else begin
         r_ram_wr <= w_load_hs;
         if (w_start) r_wcnt <= '0;
         if (w_load_hs) begin
            r_ram_addr <= r_wcnt;
            r_ram_din  <= load_data;
            r_wcnt     <= r_wcnt + AW'(1);
         end else if (w_issue) begin
            r_ram_addr <= w_addr;
         end
      end
   end

   // Window scan counters: kx fastest, then ky, ox, oy; all wrap to 0 after the last read
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_kx <= '0;
         r_ky <= '0;
         r_ox <= '0;
         r_oy <= '0;
      end else if (w_start) begin
         r_kx <= '0;
         r_ky <= '0;
         r_ox <= '0;
         r_oy <= '0;
      end else if (w_issue) begin
         if (r_kx == KW'(K-1)) begin
            r_kx <= '0;
            if (r_ky == KW'(K-1)) begin
               r_ky <= '0;
               if (r_ox == OXW'(OUT_W-1)) begin
                  r_ox <= '0;
                  r_oy <= (r_oy == OYW'(OUT_H-1)) ? '0 : r_oy + OYW'(1);
               end else begin
                  r_ox <= r_ox + OXW'(1);
               end
            end else begin
               r_ky <= r_ky + KW'(1);
            end
         end else begin
            r_kx <= r_kx + KW'(1);
         end
      end
   end

   // Strobe pipeline: address on the bus one cycle, RAM data and strobe the next
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_vld   <= 1'b0;
         r_rd_first <= 1'b0;
         r_in_st    <= 1'b0;
         r_first    <= 1'b0;
      end else begin
         r_rd_vld   <= w_issue;
         r_rd_first <= w_win_issue;
         r_in_st    <= r_rd_vld;
         r_first    <= r_rd_first;
      end
   end

   // Outstanding windows and accepted-result count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_outst <= '0;
         r_rcnt  <= '0;
      end else if (w_start) begin
         r_outst <= '0;
         r_rcnt  <= '0;
      end else begin
         unique case ({w_win_issue, w_res_acc})
            2'b10:   r_outst <= r_outst + CW'(1);
            2'b01:   r_outst <= r_outst - CW'(1);
            default: ;
         endcase
         r_rcnt <= r_rcnt + RCW'(w_res_acc);
      end
   end

   conv_res_fifo #(
      .RW        (RW),
      .FIFO_DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk  (clk),
      .rst_n(rst_n),
      .push (w_res_acc),
      .din  (conv_dout),
      .pop  (w_pop),
      .dout (res_data),
      .valid(w_fifo_valid),
      .count(w_fifo_count)
   );

`ifdef CONV_SCHED_PERF_EN
   logic [15:0] r_stall;

   // Count SCAN cycles where a window start was held back by the gate; saturating
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                               r_stall <= '0;
      else if (w_start)                                         r_stall <= '0;
      else if ((r_state == SCAN) && w_win_start && !w_gate_ok &&
               (r_stall != '1))                                 r_stall <= r_stall + 16'd1;
   end

   assign stall_cycles = r_stall;
`endif

`ifndef SYNTHESIS
   a_no_orphan_result: assert property (@(posedge clk) disable iff (!rst_n)
      !(conv_out_st && (r_outst == '0)))
      else $error("conv_sched: conv_out_st with no window outstanding; result dropped");
`endif

   assign ram_wr     = r_ram_wr;
   assign ram_addr   = r_ram_addr;
   assign ram_din    = r_ram_din;
   assign conv_in_st = r_in_st;
   assign conv_first = r_first;
   assign res_valid  = w_fifo_valid;

endmodule

// File: tb/tb_conv_sched.sv
// Directed bench for conv_sched with a behavioural sync RAM and a 5-cycle
// window-sum Conv model.
module tb_conv_sched;
   import conv_pkg::*;

   localparam int unsigned AW = 6;
   localparam int unsigned DW = 8;
   localparam int unsigned RW = 16;

   logic          clk, rst_n, start, load_valid, load_ready;
   logic [DW-1:0] load_data;
   logic          ram_wr;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic          conv_in_st, conv_first, conv_out_st;
   logic [RW-1:0] conv_dout;
   logic          res_valid, res_ready, busy, done;
   logic [RW-1:0] res_data;
`ifdef CONV_SCHED_PERF_EN
   logic [15:0]   stall_cycles;
`endif

   conv_sched #(.AW(AW), .DW(DW), .RW(RW), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
      .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_din(ram_din),
      .conv_in_st(conv_in_st), .conv_first(conv_first),
      .conv_dout(conv_dout), .conv_out_st(conv_out_st),
      .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
      .busy(busy),
`ifdef CONV_SCHED_PERF_EN
      .stall_cycles(stall_cycles),
`endif
      .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural pixel RAM, 1-cycle read latency
   logic [DW-1:0] mem [64];
   logic [DW-1:0] ram_dout;
   always @(posedge clk) begin
      if (ram_wr) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
   end

   // Conv model: accumulate 9 strobed pixels, return the sum 5 cycles later
   logic [RW-1:0] acc;
   int unsigned   pcnt;
   logic [4:0]    dv;
   logic [RW-1:0] dd [5];
   logic [RW-1:0] w_sum;
   int unsigned   w_n;
   assign w_sum = (conv_first ? '0 : acc) + RW'(ram_dout);
   assign w_n   = conv_first ? 1 : pcnt + 1;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc  <= '0;
         pcnt <= 0;
         dv   <= '0;
         for (int i = 0; i < 5; i++) dd[i] <= '0;
      end else begin
         for (int i = 4; i > 0; i--) dd[i] <= dd[i-1];
         dv    <= {dv[3:0], conv_in_st && (w_n == 9)};
         dd[0] <= w_sum;
         if (conv_in_st) begin
            acc  <= w_sum;
            pcnt <= (w_n == 9) ? 0 : w_n;
         end
      end
   end
   assign conv_out_st = dv[4];
   assign conv_dout   = dd[4];

   // Pixel values of the frame currently being loaded
   logic [7:0] pix [64];

   // Monitors, sampled on the falling edge
   int unsigned    wr_cnt = 0, wr_bad = 0, win_started = 0, popped = 0, done_cnt = 0;
   logic [AW-1:0]  prev_addr = '0;
   logic [AW-1:0]  sa [$];
   logic           sf [$];
   logic [RW-1:0]  rq [$];
   always @(negedge clk) begin
      if (ram_wr) begin
         if ((ram_addr != AW'(wr_cnt % 64)) || (ram_din != pix[ram_addr])) wr_bad <= wr_bad + 1;
         wr_cnt <= wr_cnt + 1;
      end
      if (conv_in_st) begin
         sa.push_back(prev_addr);
         sf.push_back(conv_first);
         if (conv_first) win_started <= win_started + 1;
      end
      prev_addr <= ram_addr;
      if (res_valid && res_ready) begin
         rq.push_back(res_data);
         popped <= popped + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
   end

   int unsigned errs = 0, checks = 0;
   int unsigned wsb = 0, pb = 0, max_occ = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      int unsigned occ;
      @(posedge clk);
      #1;
      occ = (win_started - wsb) - (popped - pb);
      if (occ > max_occ) max_occ = occ;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic load_frame();
      int unsigned k = 0;
      int unsigned budget = 500;
      while (k < 64 && budget > 0) begin
         if (load_ready) begin
            load_valid = 1'b1;
            load_data  = pix[k];
            k++;
         end else begin
            load_valid = 1'b0;
         end
         tick();
         budget--;
      end
      load_valid = 1'b0;
      chk("load_accepted", k, 64);
   endtask

   task automatic wait_done(input string tag);
      int unsigned b  = 4000;
      int unsigned d0 = done_cnt;
      while (done_cnt == d0 && b > 0) begin
         tick();
         b--;
      end
      chk({tag, "_done_seen"}, done_cnt != d0, 1);
   endtask

   function automatic int unsigned win_sum(input int unsigned oy, input int unsigned ox);
      int unsigned s = 0;
      for (int unsigned ky = 0; ky < K; ky++)
         for (int unsigned kx = 0; kx < K; kx++)
            s += pix[(oy + ky) * IMG_W + ox + kx];
      return s;
   endfunction

   task automatic check_results(input string tag, input int unsigned rb);
      chk({tag, "_res_count"}, rq.size() - rb, 36);
      for (int unsigned w = 0; w < 36; w++)
         chk($sformatf("%s_res%0d", tag, w), rq[rb + w], win_sum(w / 6, w % 6));
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ctl"}, {load_ready, ram_wr, conv_in_st, conv_first, res_valid, busy, done}, 0);
      chk({tag, "_addr"}, ram_addr, 0);
      chk({tag, "_din"}, ram_din, 0);
      chk({tag, "_res_data"}, res_data, 0);
   endtask

   int unsigned exp0 [9]  = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
   int unsigned exp35 [9] = '{45, 46, 47, 53, 54, 55, 61, 62, 63};

   initial begin
      int unsigned wb, sb, rb, db;
`ifdef CONV_SCHED_PERF_EN
      logic [15:0] s1, s2;
`endif
      rst_n = 1'b0; start = 1'b0; load_valid = 1'b0; load_data = '0; res_ready = 1'b0;
      for (int i = 0; i < 64; i++) pix[i] = 8'(i);
      repeat (3) tick();
      check_reset_outputs("reset");
      rst_n = 1'b1;
      tick();

      // Frame 1: pixels 0..63, downstream always ready
      res_ready = 1'b1;
      wb = wr_cnt; sb = sa.size(); rb = rq.size(); db = done_cnt;
      pulse_start();
      chk("load_ready_in_load", load_ready, 1);
      chk("busy_in_load", busy, 1);
      load_frame();
      tick(); tick();
      chk("wr_count", wr_cnt - wb, 64);
      chk("wr_addr_data_bad", wr_bad, 0);
      chk("load_ready_after_load", load_ready, 0);
      chk("busy_in_scan", busy, 1);
      wait_done("f1");
      tick(); tick();
      chk("f1_done_once", done_cnt - db, 1);
      chk("f1_busy_idle", busy, 0);
      for (int unsigned i = 0; i < 9; i++) begin
         chk($sformatf("win0_addr%0d", i), sa[sb + i], exp0[i]);
         chk($sformatf("win0_first%0d", i), sf[sb + i], (i == 0) ? 1 : 0);
      end
      chk("win1_start_addr", sa[sb + 9], 1);
      chk("win1_first", sf[sb + 9], 1);
      chk("win6_start_addr", sa[sb + 54], 8);
      for (int unsigned i = 0; i < 9; i++)
         chk($sformatf("win35_addr%0d", i), sa[sb + 315 + i], exp35[i]);
      chk("f1_strobes", sa.size() - sb, 324);
      chk("f1_first_result", rq[rb], 81);
      check_results("f1", rb);

      // Frame 2: backpressure, plus a start pulse while busy
      for (int i = 0; i < 64; i++) pix[i] = 8'((i * 7 + 3) & 255);
      res_ready = 1'b0;
      wr_bad = wr_bad;
      rb = rq.size(); db = done_cnt;
      wsb = win_started; pb = popped; max_occ = 0;
      pulse_start();
      load_frame();
      for (int i = 0; i < 60; i++) begin
         if (i == 20) start = 1'b1;
         tick();
         start = 1'b0;
      end
      chk("stall_windows", win_started - wsb, 4);
      chk("stall_no_pops", popped - pb, 0);
      chk("stall_fifo_valid", res_valid, 1);
      chk("stall_fifo_head", res_data, win_sum(0, 0));
      chk("start_ignored_busy", busy, 1);
      chk("start_ignored_load_ready", load_ready, 0);
`ifdef CONV_SCHED_PERF_EN
      s1 = stall_cycles;
      chk("perf_nonzero", s1 != 0, 1);
      repeat (5) tick();
      chk("perf_counting", stall_cycles - s1, 5);
`endif
      res_ready = 1'b1;
      wait_done("f2");
      tick(); tick();
      chk("f2_done_once", done_cnt - db, 1);
      chk("f2_max_occ_le4", max_occ <= 4, 1);
      check_results("f2", rb);
`ifdef CONV_SCHED_PERF_EN
      s2 = stall_cycles;
      repeat (5) tick();
      chk("perf_frozen", stall_cycles, s2);
`endif

      // Frame 3: reset during window 10
      for (int i = 0; i < 64; i++) pix[i] = 8'(255 - i);
      db = done_cnt; wsb = win_started; pb = popped;
      pulse_start();
      load_frame();
      begin
         int unsigned b = 1000;
         while ((win_started - wsb) < 11 && b > 0) begin
            tick();
            b--;
         end
         chk("reach_window10", (win_started - wsb) >= 11, 1);
      end
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("abort");
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (2) tick();
      chk("abort_no_done", done_cnt - db, 0);
      chk("abort_idle", busy, 0);

      // Frame 4: full frame after abort
      for (int i = 0; i < 64; i++) pix[i] = 8'((i * 13) & 255);
      wb = wr_cnt; sb = sa.size(); rb = rq.size(); db = done_cnt;
      wsb = win_started; pb = popped; max_occ = 0;
      pulse_start();
      load_frame();
      wait_done("f4");
      tick(); tick();
      chk("f4_wr_count", wr_cnt - wb, 64);
      chk("f4_wr_bad", wr_bad, 0);
      chk("f4_done_once", done_cnt - db, 1);
      chk("f4_strobes", sa.size() - sb, 324);
      chk("f4_busy_idle", busy, 0);
      check_results("f4", rb);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
